// File: rtl/reg_bank_ctrl.sv
// Fetch/decode/execute controller for a 4-entry register bank and an external ALU.
// Instructions are 8 bits: opcode [7:4], ra [3:2], rb [1:0].
module reg_bank_ctrl #(
    parameter int unsigned     BITS     = 8,
    parameter logic [BITS-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [BITS-1:0] mem_addr,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [1:0]      address_a,
    output logic [1:0]      address_b,
    output logic [1:0]      write_address,
    output logic [BITS-1:0] write_data,
    output logic            write_enable,
    input  logic [BITS-1:0] reg_data_a,
    input  logic [BITS-1:0] reg_data_b,
    output logic [3:0]      alu_op,
    input  logic [BITS-1:0] alu_result,
    output logic [BITS-1:0] pc,
    output logic            halted
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalt} state_e;

    localparam logic [3:0] OpLastAlu = 4'h5;
    localparam logic [3:0] OpLd      = 4'h6;
    localparam logic [3:0] OpSt      = 4'h7;
    localparam logic [3:0] OpBrz     = 4'h8;
    localparam logic [3:0] OpHalt    = 4'hF;
    localparam logic [7:0] IrNop     = 8'h90;

    state_e          state_q;
    logic [7:0]      ir_q;
    logic [BITS-1:0] pc_q;
    logic [3:0]      opcode;
    logic            is_alu;

    assign opcode = ir_q[7:4];
    assign is_alu = (opcode <= OpLastAlu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            ir_q    <= IrNop;
            pc_q    <= PC_RESET;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata[7:0];
                        pc_q    <= pc_q + BITS'(1);
                        state_q <= StDecode;
                    end
                end
                StDecode: state_q <= StExec;
                StExec: begin
                    if (is_alu) begin
                        state_q <= StFetch;
                    end else if (opcode == OpLd || opcode == OpSt) begin
                        state_q <= StMem;
                    end else if (opcode == OpBrz) begin
                        if (reg_data_a == '0) begin
                            pc_q <= reg_data_b;
                        end
                        state_q <= StFetch;
                    end else if (opcode == OpHalt) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        state_q <= StFetch;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        mem_addr     = pc_q;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        write_enable = 1'b0;
        alu_op       = 4'h0;
        case (state_q)
            StFetch: mem_read_en = 1'b1;
            StExec: begin
                alu_op       = opcode;
                write_enable = is_alu;
            end
            StMem: begin
                mem_addr     = reg_data_b;
                mem_read_en  = (opcode == OpLd);
                mem_write_en = (opcode == OpSt);
                // Load data lands in the bank on the same edge the access completes.
                write_enable = (opcode == OpLd) && mem_ready;
            end
            default: ;
        endcase
        if (rst) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            write_enable = 1'b0;
            alu_op       = 4'h0;
        end
    end

    assign halted        = (state_q == StHalt) && !rst;
    assign mem_wdata     = reg_data_a;
    assign address_a     = ir_q[3:2];
    assign address_b     = ir_q[1:0];
    assign write_address = ir_q[3:2];
    assign write_data    = (opcode == OpLd) ? mem_rdata : alu_result;
    assign pc            = pc_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: memory, register bank and ALU models around the DUT;
// expected bus events are queued by the stimulus and matched by an independent monitor.
module tb_reg_bank_ctrl;

    localparam logic [1:0] KF = 2'd0;  // instruction fetch completes
    localparam logic [1:0] KW = 2'd1;  // bank write
    localparam logic [1:0] KS = 2'd2;  // memory store completes

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, write_data;
    logic [7:0] reg_data_a, reg_data_b, alu_result, pc;
    logic       mem_read_en, mem_write_en, mem_ready, write_enable, halted;
    logic [1:0] address_a, address_b, write_address;
    logic [3:0] alu_op;

    logic [7:0] mem [256];
    logic [7:0] bank [4];
    logic [7:0] preset [4];
    logic       do_preset;
    int         slow_wait;
    int         wcnt;
    int         cyc;
    int         total = 0;
    int         bad = 0;
    ev_t        exp_q [$];
    ev_t        got, want;
    logic       got_valid;

    reg_bank_ctrl #(.BITS(8), .PC_RESET(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_address(write_address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .reg_data_a   (reg_data_a),
        .reg_data_b   (reg_data_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Addresses 0x20-0x2F are slow: ready after slow_wait wait cycles.
    assign mem_rdata  = mem[mem_addr];
    assign mem_ready  = (mem_read_en || mem_write_en)
                        && ((mem_addr[7:4] != 4'h2) || (wcnt >= slow_wait));
    assign reg_data_a = bank[address_a];
    assign reg_data_b = bank[address_b];

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            4'h0: alu_result = reg_data_a + reg_data_b;
            4'h1: alu_result = reg_data_a - reg_data_b;
            4'h2: alu_result = reg_data_a & reg_data_b;
            4'h3: alu_result = reg_data_a | reg_data_b;
            4'h4: alu_result = ~reg_data_a;
            4'h5: alu_result = reg_data_a >> 1;
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (rst || !(mem_read_en || mem_write_en) || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        cyc <= rst ? 1 : cyc + 1;
    end

    always @(posedge clk) begin
        if (do_preset) begin
            for (int i = 0; i < 4; i++) bank[i] <= preset[i];
        end else if (write_enable) begin
            bank[write_address] <= write_data;
        end
    end

    // Monitor: one observable event per cycle at most; a load completion counts as a write.
    always @(negedge clk) begin
        if (!rst) begin
            got_valid = 1'b0;
            got = '0;
            if (write_enable) begin
                got = '{kind: KW, cyc: 32'(cyc), addr: {6'b0, write_address}, data: write_data};
                got_valid = 1'b1;
            end else if (mem_write_en && mem_ready) begin
                got = '{kind: KS, cyc: 32'(cyc), addr: mem_addr, data: mem_wdata};
                got_valid = 1'b1;
            end else if (mem_read_en && mem_ready) begin
                got = '{kind: KF, cyc: 32'(cyc), addr: mem_addr, data: 8'h00};
                got_valid = 1'b1;
            end
            if (got_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: actual kind=%0d cyc=%0d addr=%h data=%h required none",
                             got.kind, got.cyc, got.addr, got.data);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL bus_event: actual kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
                                 got.kind, got.cyc, got.addr, got.data,
                                 want.kind, want.cyc, want.addr, want.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] k, input int c, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{kind: k, cyc: 32'(c), addr: a, data: d});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic set_bank(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
        preset[0] = r0;
        preset[1] = r1;
        preset[2] = r2;
        preset[3] = r3;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        do_preset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_preset = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_test(input string name);
        check({"queue_empty_", name}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        do_preset = 1'b1;
        slow_wait = 0;
        clear_mem();
        set_bank(8'h00, 8'h00, 8'h00, 8'h00);

        // ADD r0,r1 with r0=3, r1=5
        clear_mem();
        mem[0] = 8'h01;
        set_bank(8'h03, 8'h05, 8'h00, 8'h00);
        push(KF, 1, 8'h00, 8'h00);
        push(KW, 3, 8'h00, 8'h08);
        push(KF, 4, 8'h01, 8'h00);
        reset_dut();
        run_to(2);
        check("add_pc_after_fetch", 32'(pc), 32'd1);
        run_to(10);
        check("add_halted", 32'(halted), 32'd1);
        check("add_pc_final", 32'(pc), 32'd2);
        end_test("add");

        // LD r2,[r3] with two wait cycles
        clear_mem();
        mem[0] = 8'h6B;
        mem[8'h20] = 8'hA5;
        slow_wait = 2;
        set_bank(8'h00, 8'h00, 8'h11, 8'h20);
        push(KF, 1, 8'h00, 8'h00);
        push(KW, 6, 8'h02, 8'hA5);
        push(KF, 7, 8'h01, 8'h00);
        reset_dut();
        run_to(12);
        check("ld_bank_r2", 32'(bank[2]), 32'h0000_00A5);
        end_test("ld");

        // ST r1,[r0]
        clear_mem();
        mem[0] = 8'h74;
        set_bank(8'h10, 8'h7E, 8'h00, 8'h00);
        push(KF, 1, 8'h00, 8'h00);
        push(KS, 4, 8'h10, 8'h7E);
        push(KF, 5, 8'h01, 8'h00);
        reset_dut();
        run_to(10);
        check("st_bank_r1", 32'(bank[1]), 32'h0000_007E);
        end_test("st");

        // BRZ r0,r1 taken
        clear_mem();
        mem[0] = 8'h81;
        set_bank(8'h00, 8'h40, 8'h00, 8'h00);
        push(KF, 1, 8'h00, 8'h00);
        push(KF, 4, 8'h40, 8'h00);
        reset_dut();
        run_to(3);
        check("brz_alu_op", 32'(alu_op), 32'd8);
        run_to(10);
        check("brz_taken_pc", 32'(pc), 32'h0000_0041);
        end_test("brz_taken");

        // BRZ r0,r1 not taken
        clear_mem();
        mem[0] = 8'h81;
        set_bank(8'h01, 8'h40, 8'h00, 8'h00);
        push(KF, 1, 8'h00, 8'h00);
        push(KF, 4, 8'h01, 8'h00);
        reset_dut();
        run_to(10);
        check("brz_not_taken_pc", 32'(pc), 32'd2);
        end_test("brz_not_taken");

        // Branch to 0xFF, NOP there, wrap to 0x00 which now holds HALT
        clear_mem();
        mem[0] = 8'h81;
        mem[8'hFF] = 8'h90;
        set_bank(8'h00, 8'hFF, 8'h00, 8'h00);
        push(KF, 1, 8'h00, 8'h00);
        push(KF, 4, 8'hFF, 8'h00);
        push(KF, 7, 8'h00, 8'h00);
        reset_dut();
        run_to(2);
        mem[0] = 8'hF0;
        run_to(5);
        check("wrap_pc", 32'(pc), 32'd0);
        run_to(10);
        check("wrap_halted", 32'(halted), 32'd1);
        check("wrap_pc_final", 32'(pc), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read_en) n++;
        end
        check("halt_no_reads", 32'(n), 32'd0);
        end_test("wrap_halt");

        // Reset while LD is stalled in MEM
        clear_mem();
        mem[0] = 8'h6B;
        slow_wait = 100;
        set_bank(8'h00, 8'h00, 8'h33, 8'h20);
        push(KF, 1, 8'h00, 8'h00);
        reset_dut();
        run_to(5);
        check("mid_ld_read_en", 32'(mem_read_en), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_read_en", 32'(mem_read_en), 32'd0);
        check("abort_mem_write_en", 32'(mem_write_en), 32'd0);
        check("abort_write_enable", 32'(write_enable), 32'd0);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        mem[0] = 8'hF0;
        push(KF, 1, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_to(6);
        check("abort_halted", 32'(halted), 32'd1);
        check("abort_pc_after", 32'(pc), 32'd1);
        check("abort_bank_r2", 32'(bank[2]), 32'h0000_0033);
        end_test("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
